// File: rtl/or1300_store_buffer.sv
// Store buffer: steers byte/halfword/word stores onto big-endian byte lanes,
// queues them in a small FIFO and drains them over a request/grant/end bus.
module or1300_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        storeValid,
  input  logic [1:0]  storeSize,
  input  logic [31:0] storeAddress,
  input  logic [31:0] storeData,
  output logic        storeReady,
  output logic        misalignedStore,
  input  logic [31:0] loadCheckAddress,
  output logic        loadHazard,
  output logic        bufferEmpty,
  output logic        busRequest,
  input  logic        busGrant,
  output logic [31:0] busAddress,
  output logic [3:0]  busByteEnables,
  output logic [31:0] busData,
  output logic        busWrite,
  input  logic        busEndTransaction,
  input  logic        busError,
  output logic        storeBusError
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} size_e;
  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_TRANSFER, S_WAIT} state_e;

  typedef struct packed {
    logic [29:0] word_addr;
    logic [3:0]  be;
    logic [31:0] data;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  state_e           state;

  entry_t incoming;
  entry_t head;
  logic   aligned;
  logic   push;
  logic   pop;

  // Only the word address of a load matters for hazard detection.
  logic unused_load_offset;
  assign unused_load_offset = ^loadCheckAddress[1:0];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    incoming.word_addr = storeAddress[31:2];
    incoming.be        = 4'b0000;
    incoming.data      = 32'h0;
    aligned            = 1'b0;
    case (size_e'(storeSize))
      SZ_BYTE: begin
        aligned       = 1'b1;
        incoming.be   = 4'b1000 >> storeAddress[1:0];
        incoming.data = {4{storeData[7:0]}};
      end
      SZ_HALF: begin
        aligned       = ~storeAddress[0];
        incoming.be   = storeAddress[1] ? 4'b0011 : 4'b1100;
        incoming.data = {2{storeData[15:0]}};
      end
      SZ_WORD: begin
        aligned       = (storeAddress[1:0] == 2'b00);
        incoming.be   = 4'b1111;
        incoming.data = storeData;
      end
      default: aligned = 1'b0;
    endcase
  end

  assign storeReady  = (count != FULL);
  assign push        = storeValid & storeReady & aligned;
  assign pop         = ((state == S_TRANSFER) || (state == S_WAIT)) & busEndTransaction;
  assign bufferEmpty = (count == '0) && (state == S_IDLE);
  assign head        = mem[rd_ptr];

  // The in-flight head stays valid until popped, so it still blocks loads.
  always_comb begin
    loadHazard = push && (storeAddress[31:2] == loadCheckAddress[31:2]);
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (mem[i].word_addr == loadCheckAddress[31:2])) loadHazard = 1'b1;
    end
  end

  // NOTE: the payload array carries no reset; the valid bits alone decide
  // whether an entry means anything, so a reset only needs to clear those.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= incoming;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + AW'(1);
      end
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      busRequest      <= 1'b0;
      busWrite        <= 1'b0;
      busAddress      <= 32'h0;
      busByteEnables  <= 4'b0000;
      busData         <= 32'h0;
      misalignedStore <= 1'b0;
      storeBusError   <= 1'b0;
    end else begin
      misalignedStore <= storeValid & ~aligned;
      storeBusError   <= 1'b0;
      case (state)
        S_IDLE: begin
          // Looking at push as well lets the request rise right after acceptance.
          if ((count != '0) || push) begin
            state      <= S_REQUEST;
            busRequest <= 1'b1;
          end
        end
        S_REQUEST: begin
          if (busGrant) begin
            state          <= S_TRANSFER;
            busWrite       <= 1'b1;
            busAddress     <= {head.word_addr, 2'b00};
            busByteEnables <= head.be;
            busData        <= head.data;
          end
        end
        S_TRANSFER, S_WAIT: begin
          if (busEndTransaction) begin
            state          <= S_IDLE;
            busRequest     <= 1'b0;
            busWrite       <= 1'b0;
            busAddress     <= 32'h0;
            busByteEnables <= 4'b0000;
            busData        <= 32'h0;
            storeBusError  <= busError;
          end else begin
            state    <= S_WAIT;
            busWrite <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_or1300_store_buffer.sv
// Directed bench for or1300_store_buffer: expected bus writes go into a
// scoreboard queue, a monitor pops and compares on every bus write strobe.
module tb_or1300_store_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        storeValid;
  logic [1:0]  storeSize;
  logic [31:0] storeAddress;
  logic [31:0] storeData;
  logic        storeReady;
  logic        misalignedStore;
  logic [31:0] loadCheckAddress;
  logic        loadHazard;
  logic        bufferEmpty;
  logic        busRequest;
  logic        busGrant;
  logic [31:0] busAddress;
  logic [3:0]  busByteEnables;
  logic [31:0] busData;
  logic        busWrite;
  logic        busEndTransaction = 1'b0;
  logic        busError = 1'b0;
  logic        storeBusError;

  logic grant_en  = 1'b0;
  logic auto_ack  = 1'b1;
  logic err_next  = 1'b0;
  int   ack_delay = 2;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   mis_pulses = 0;
  int   err_pulses = 0;

  or1300_store_buffer #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .storeValid(storeValid), .storeSize(storeSize),
    .storeAddress(storeAddress), .storeData(storeData),
    .storeReady(storeReady), .misalignedStore(misalignedStore),
    .loadCheckAddress(loadCheckAddress), .loadHazard(loadHazard),
    .bufferEmpty(bufferEmpty),
    .busRequest(busRequest), .busGrant(busGrant),
    .busAddress(busAddress), .busByteEnables(busByteEnables),
    .busData(busData), .busWrite(busWrite),
    .busEndTransaction(busEndTransaction), .busError(busError),
    .storeBusError(storeBusError)
  );

  always #5 clock = ~clock;
  assign busGrant = grant_en;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: counts pulses and scores every bus write against the queue.
  always @(negedge clock) begin
    if (misalignedStore) mis_pulses++;
    if (storeBusError) err_pulses++;
    if (busWrite) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h, expected no write", busAddress);
      end else begin
        mon_e = exp_q.pop_front();
        check("bus_addr", busAddress, mon_e.addr);
        check("bus_be", {28'h0, busByteEnables}, {28'h0, mon_e.be});
        check("bus_data", busData, mon_e.data);
      end
    end
  end

  // Bus slave: acknowledges each write strobe after ack_delay cycles.
  always begin
    @(negedge clock);
    if (busWrite && auto_ack) begin
      repeat (ack_delay) @(negedge clock);
      busEndTransaction = 1'b1;
      busError          = err_next;
      @(negedge clock);
      busEndTransaction = 1'b0;
      busError          = 1'b0;
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic do_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_data);
    logic rdy;
    int   waited;
    rdy    = 1'b0;
    waited = 0;
    storeValid   = 1'b1;
    storeSize    = size;
    storeAddress = addr;
    storeData    = data;
    while (!rdy && waited < 100) begin
      @(negedge clock);
      rdy = storeReady;
      @(posedge clock);
      #1;
      waited++;
    end
    storeValid = 1'b0;
    check("store_accept", {31'h0, rdy}, 32'h1);
    if (rdy) exp_q.push_back('{e_addr, e_be, e_data});
  endtask

  task automatic offer_bad(input logic [1:0] size, input logic [31:0] addr);
    storeValid   = 1'b1;
    storeSize    = size;
    storeAddress = addr;
    storeData    = 32'hDEADBEEF;
    @(posedge clock);
    #1;
    storeValid = 1'b0;
    @(negedge clock);
    check("mis_pulse_hi", {31'h0, misalignedStore}, 32'h1);
    check("bad_no_request", {31'h0, busRequest}, 32'h0);
    check("bad_empty", {31'h0, bufferEmpty}, 32'h1);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("mis_pulse_lo", {31'h0, misalignedStore}, 32'h0);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    @(negedge clock);
    while (!bufferEmpty && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("drain_empty", {31'h0, bufferEmpty}, 32'h1);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    storeValid = 1'b0;
    storeSize = 2'b00;
    storeAddress = 32'h0;
    storeData = 32'h0;
    loadCheckAddress = 32'h0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_ready", {31'h0, storeReady}, 32'h1);
    check("rst_empty", {31'h0, bufferEmpty}, 32'h1);
    check("rst_hazard", {31'h0, loadHazard}, 32'h0);
    check("rst_request", {31'h0, busRequest}, 32'h0);
    check("rst_mis", {31'h0, misalignedStore}, 32'h0);
    @(posedge clock);
    #1;

    // Byte store, immediate grant, ack two cycles after the write strobe.
    grant_en = 1'b1;
    ack_delay = 2;
    do_store(2'b00, 32'h0000_1003, 32'h0000_00A5, 32'h0000_1000, 4'b0001, 32'hA5A5_A5A5);
    @(negedge clock);
    check("req_latency", {31'h0, busRequest}, 32'h1);
    check("busy_not_empty", {31'h0, bufferEmpty}, 32'h0);
    @(posedge clock);
    #1;
    wait_empty();

    // Two halfwords, completion arriving in the write cycle itself.
    ack_delay = 0;
    do_store(2'b01, 32'h0000_2000, 32'h0000_1234, 32'h0000_2000, 4'b1100, 32'h1234_1234);
    do_store(2'b01, 32'h0000_2002, 32'h0000_BEEF, 32'h0000_2000, 4'b0011, 32'hBEEF_BEEF);
    wait_empty();

    // Fill with grant withheld; the fifth store waits for the first drain.
    grant_en = 1'b0;
    ack_delay = 1;
    do_store(2'b10, 32'h0000_6000, 32'h1111_1111, 32'h0000_6000, 4'b1111, 32'h1111_1111);
    do_store(2'b10, 32'h0000_6004, 32'h2222_2222, 32'h0000_6004, 4'b1111, 32'h2222_2222);
    do_store(2'b10, 32'h0000_6008, 32'h3333_3333, 32'h0000_6008, 4'b1111, 32'h3333_3333);
    do_store(2'b10, 32'h0000_600C, 32'h4444_4444, 32'h0000_600C, 4'b1111, 32'h4444_4444);
    @(negedge clock);
    check("full_not_ready", {31'h0, storeReady}, 32'h0);
    @(posedge clock);
    #1;
    fork
      do_store(2'b10, 32'h0000_6010, 32'h5555_5555, 32'h0000_6010, 4'b1111, 32'h5555_5555);
      begin
        repeat (3) @(negedge clock);
        check("held_off", {31'h0, storeReady}, 32'h0);
        check("req_waiting", {31'h0, busRequest}, 32'h1);
        grant_en = 1'b1;
      end
    join
    wait_empty();

    // Misaligned and reserved-size offers.
    offer_bad(2'b01, 32'h0000_3001);
    offer_bad(2'b10, 32'h0000_3002);
    offer_bad(2'b11, 32'h0000_3000);
    check("mis_pulse_count", mis_pulses, 32'd3);

    // Load hazard against a pending word.
    grant_en = 1'b0;
    loadCheckAddress = 32'h0000_400B;
    do_store(2'b10, 32'h0000_4008, 32'hCAFE_F00D, 32'h0000_4008, 4'b1111, 32'hCAFE_F00D);
    @(negedge clock);
    check("hazard_hit", {31'h0, loadHazard}, 32'h1);
    @(posedge clock);
    #1 loadCheckAddress = 32'h0000_400C;
    @(negedge clock);
    check("hazard_miss", {31'h0, loadHazard}, 32'h0);
    @(posedge clock);
    #1 loadCheckAddress = 32'h0000_400B;
    grant_en = 1'b1;
    wait_empty();
    @(negedge clock);
    check("hazard_cleared", {31'h0, loadHazard}, 32'h0);
    @(posedge clock);
    #1;

    // Erroneous completion still pops and pulses storeBusError.
    ack_delay = 2;
    err_next = 1'b1;
    do_store(2'b10, 32'h0000_5000, 32'h0BAD_BEEF, 32'h0000_5000, 4'b1111, 32'h0BAD_BEEF);
    wait_empty();
    err_next = 1'b0;
    check("bus_err_pulses", err_pulses, 32'd1);
    check("err_ready", {31'h0, storeReady}, 32'h1);

    // Reset while the head waits for completion with three entries queued.
    auto_ack = 1'b0;
    do_store(2'b10, 32'h0000_7000, 32'hAAAA_0000, 32'h0000_7000, 4'b1111, 32'hAAAA_0000);
    do_store(2'b10, 32'h0000_7004, 32'hAAAA_0004, 32'h0000_7004, 4'b1111, 32'hAAAA_0004);
    do_store(2'b10, 32'h0000_7008, 32'hAAAA_0008, 32'h0000_7008, 4'b1111, 32'hAAAA_0008);
    loadCheckAddress = 32'h0000_7004;
    @(negedge clock);
    check("wait_request", {31'h0, busRequest}, 32'h1);
    check("wait_no_write", {31'h0, busWrite}, 32'h0);
    check("wait_hazard", {31'h0, loadHazard}, 32'h1);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("rstw_request", {31'h0, busRequest}, 32'h0);
    check("rstw_write", {31'h0, busWrite}, 32'h0);
    check("rstw_addr", busAddress, 32'h0);
    check("rstw_be", {28'h0, busByteEnables}, 32'h0);
    check("rstw_data", busData, 32'h0);
    check("rstw_empty", {31'h0, bufferEmpty}, 32'h1);
    check("rstw_hazard", {31'h0, loadHazard}, 32'h0);
    check("rstw_err", {31'h0, storeBusError}, 32'h0);
    check("rstw_err_count", err_pulses, 32'd1);
    auto_ack = 1'b1;
    @(posedge clock);
    #1;

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
